// File: rtl/ahb_arb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_arb_pkg
// Shared encodings for the two-master AHB-Lite debug arbiter.
//   htrans_e  : AHB transfer types (IDLE/BUSY/NONSEQ/SEQ)
//   hresp_e   : AHB-Lite response (OKAY/ERROR)
//   owner_e   : data-phase owner (none, master 0, master 1)
//   trans_active() : true for transfer types that carry a real request
// ----------------------------------------------------------------------------
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    // SEQ is handled like NONSEQ; BUSY is handled like IDLE.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == NONSEQ) || (htrans == SEQ);
    endfunction

endpackage

// File: rtl/ahb_arb_pend.sv
// ----------------------------------------------------------------------------
// ahb_arb_pend
// Holds one master's captured address phase while it waits for the bus.
// Ports:
//   HCLK, HRESETn          : clock, async active-low reset
//   capture                : load haddr/hwrite/hsize and mark valid
//   clear                  : captured transfer was accepted by the slave
//   haddr, hwrite, hsize   : live address-phase signals of the master
//   vld, addr, write, size : captured request
// ----------------------------------------------------------------------------
module ahb_arb_pend #(
    parameter int unsigned AW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          capture,
    input  logic          clear,
    input  logic [AW-1:0] haddr,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    output logic          vld,
    output logic [AW-1:0] addr,
    output logic          write,
    output logic [2:0]    size
);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vld   <= 1'b0;
            addr  <= '0;
            write <= 1'b0;
            size  <= 3'd0;
        end else begin
            if (clear) begin
                vld <= 1'b0;
            end else if (capture) begin
                vld <= 1'b1;
            end
            if (capture) begin
                addr  <= haddr;
                write <= hwrite;
                size  <= hsize;
            end
        end
    end

endmodule

// File: rtl/ahb_dbg_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_dbg_arbiter
// Two-master, one-slave AHB-Lite arbiter. Master 1 (debug) has fixed priority
// over master 0 (CPU). A losing master's address phase is captured and the
// master is held off through its private HREADY until the transfer is replayed
// and its data phase completes.
//
// Ports:
//   HCLK, HRESETn                       : clock, async active-low reset
//   Mn_HADDR/HTRANS/HWRITE/HSIZE/HWDATA : master n request (n = 0, 1)
//   Mn_HRDATA/HREADY/HRESP              : master n response
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA    : slave-side request
//   HRDATA/HREADY/HRESP                 : slave-side response
//   HMASTER                             : current address-phase owner
//
// Build option: define AHB_ARB_STARVE_GUARD_EN to force a master 0 grant after
// STARVE_LIMIT consecutive master 1 grants taken while master 0 was waiting.
// ----------------------------------------------------------------------------
module ahb_dbg_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    // master 0 (CPU)
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [DW-1:0] M0_HWDATA,
    output logic [DW-1:0] M0_HRDATA,
    output logic          M0_HREADY,
    output logic          M0_HRESP,
    // master 1 (debug)
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [DW-1:0] M1_HWDATA,
    output logic [DW-1:0] M1_HRDATA,
    output logic          M1_HREADY,
    output logic          M1_HRESP,
    // slave side
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic [DW-1:0] HRDATA,
    input  logic          HREADY,
    input  logic          HRESP,
    output logic          HMASTER
);

    logic [1:0]    live;
    logic [1:0]    req;
    logic [1:0]    pend_vld;
    logic [1:0]    cap;
    logic [1:0]    clr;
    logic [AW-1:0] pend_addr0;
    logic [AW-1:0] pend_addr1;
    logic          pend_write0;
    logic          pend_write1;
    logic [2:0]    pend_size0;
    logic [2:0]    pend_size1;
    logic          force_m0;
    owner_e        win;
    owner_e        data_owner;

    // A master can only present a new address phase when it sees HREADY high
    // and has nothing captured already.
    assign live[0] = trans_active(M0_HTRANS) & ~pend_vld[0] & M0_HREADY;
    assign live[1] = trans_active(M1_HTRANS) & ~pend_vld[1] & M1_HREADY;
    assign req     = pend_vld | live;

    always_comb begin
        win = OWN_NONE;
        if (req[1] && !force_m0) begin
            win = OWN_M1;
        end else if (req[0]) begin
            win = OWN_M0;
        end
    end

    // Address-phase mux: captured request takes precedence over live inputs.
    always_comb begin
        HTRANS = IDLE;
        HADDR  = '0;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        unique case (win)
            OWN_M0: begin
                HTRANS = NONSEQ;
                HADDR  = pend_vld[0] ? pend_addr0  : M0_HADDR;
                HWRITE = pend_vld[0] ? pend_write0 : M0_HWRITE;
                HSIZE  = pend_vld[0] ? pend_size0  : M0_HSIZE;
            end
            OWN_M1: begin
                HTRANS = NONSEQ;
                HADDR  = pend_vld[1] ? pend_addr1  : M1_HADDR;
                HWRITE = pend_vld[1] ? pend_write1 : M1_HWRITE;
                HSIZE  = pend_vld[1] ? pend_size1  : M1_HSIZE;
            end
            default: ;
        endcase
    end

    assign HMASTER = (win == OWN_M1);

    // A live request that is not accepted this edge is captured; with HREADY
    // low, live already implies the master is neither owner nor pending.
    assign clr[0] = HREADY & (win == OWN_M0);
    assign clr[1] = HREADY & (win == OWN_M1);
    assign cap[0] = live[0] & ~clr[0];
    assign cap[1] = live[1] & ~clr[1];

    ahb_arb_pend #(
        .AW (AW)
    ) u_pend0 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .capture (cap[0]),
        .clear   (clr[0]),
        .haddr   (M0_HADDR),
        .hwrite  (M0_HWRITE),
        .hsize   (M0_HSIZE),
        .vld     (pend_vld[0]),
        .addr    (pend_addr0),
        .write   (pend_write0),
        .size    (pend_size0)
    );

    ahb_arb_pend #(
        .AW (AW)
    ) u_pend1 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .capture (cap[1]),
        .clear   (clr[1]),
        .haddr   (M1_HADDR),
        .hwrite  (M1_HWRITE),
        .hsize   (M1_HSIZE),
        .vld     (pend_vld[1]),
        .addr    (pend_addr1),
        .write   (pend_write1),
        .size    (pend_size1)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_owner <= OWN_NONE;
        end else if (HREADY) begin
            data_owner <= win;
        end
    end

`ifdef AHB_ARB_STARVE_GUARD_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starve_cnt;

    // Never exceeds STARVE_LIMIT: at the limit with M0 waiting, M0 wins and
    // the count clears.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            starve_cnt <= '0;
        end else if (HREADY) begin
            if (win == OWN_M0) begin
                starve_cnt <= '0;
            end else if ((win == OWN_M1) && req[0]) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign force_m0 = req[0] && (starve_cnt >= CntW'(STARVE_LIMIT));
`else
    assign force_m0 = 1'b0;
`endif

    // A zero limit would turn the guard into plain M0 priority.
    assert property (@(posedge HCLK) STARVE_LIMIT != 0);

    // Data phase
    always_comb begin
        HWDATA = '0;
        unique case (data_owner)
            OWN_M0:  HWDATA = M0_HWDATA;
            OWN_M1:  HWDATA = M1_HWDATA;
            default: HWDATA = '0;
        endcase
    end

    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;
    assign M0_HRESP  = (data_owner == OWN_M0) ? HRESP : OKAY;
    assign M1_HRESP  = (data_owner == OWN_M1) ? HRESP : OKAY;

    always_comb begin
        if (data_owner == OWN_M0) begin
            M0_HREADY = HREADY;
        end else begin
            M0_HREADY = ~pend_vld[0];
        end
        if (data_owner == OWN_M1) begin
            M1_HREADY = HREADY;
        end else begin
            M1_HREADY = ~pend_vld[1];
        end
    end

endmodule

// File: tb/tb_ahb_dbg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_dbg_arbiter
// Directed bench for ahb_dbg_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge.
// ----------------------------------------------------------------------------
module tb_ahb_dbg_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

`ifdef AHB_ARB_STARVE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] M0_HADDR, M1_HADDR;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic [31:0] M0_HWDATA, M1_HWDATA;
    logic [31:0] M0_HRDATA, M1_HRDATA;
    logic        M0_HREADY, M1_HREADY;
    logic        M0_HRESP, M1_HRESP;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        HMASTER;

    int checks = 0;
    int errors = 0;

    ahb_dbg_arbiter #(
        .AW           (32),
        .DW           (32),
        .STARVE_LIMIT (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .M0_HADDR  (M0_HADDR),
        .M0_HTRANS (M0_HTRANS),
        .M0_HWRITE (M0_HWRITE),
        .M0_HSIZE  (M0_HSIZE),
        .M0_HWDATA (M0_HWDATA),
        .M0_HRDATA (M0_HRDATA),
        .M0_HREADY (M0_HREADY),
        .M0_HRESP  (M0_HRESP),
        .M1_HADDR  (M1_HADDR),
        .M1_HTRANS (M1_HTRANS),
        .M1_HWRITE (M1_HWRITE),
        .M1_HSIZE  (M1_HSIZE),
        .M1_HWDATA (M1_HWDATA),
        .M1_HRDATA (M1_HRDATA),
        .M1_HREADY (M1_HREADY),
        .M1_HRESP  (M1_HRESP),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HMASTER   (HMASTER)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m0(input logic [1:0] t, input logic [31:0] a, input logic w,
                      input logic [31:0] wd);
        M0_HTRANS = t;
        M0_HADDR  = a;
        M0_HWRITE = w;
        M0_HSIZE  = 3'd2;
        M0_HWDATA = wd;
    endtask

    task automatic m1(input logic [1:0] t, input logic [31:0] a, input logic w,
                      input logic [31:0] wd);
        M1_HTRANS = t;
        M1_HADDR  = a;
        M1_HWRITE = w;
        M1_HSIZE  = 3'd2;
        M1_HWDATA = wd;
    endtask

    task automatic slv(input logic r, input logic e, input logic [31:0] d);
        HREADY = r;
        HRESP  = e;
        HRDATA = d;
    endtask

    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    initial begin
        HRESETn = 1'b0;
        m0(T_IDLE, 32'h0, 1'b0, 32'h0);
        m1(T_IDLE, 32'h0, 1'b0, 32'h0);
        slv(1'b1, 1'b0, 32'h0);
        M0_HSIZE = 3'd0;
        M1_HSIZE = 3'd0;

        // ---- reset values
        #2;
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_hsize", HSIZE, 3'd0);
        chk("rst_hmaster", HMASTER, 1'b0);
        chk("rst_m0_hready", M0_HREADY, 1'b1);
        chk("rst_m1_hready", M1_HREADY, 1'b1);
        chk("rst_m0_hresp", M0_HRESP, 1'b0);
        chk("rst_m1_hresp", M1_HRESP, 1'b0);
        mid();
        HRESETn = 1'b1;
        nxt();

        // ---- M0 single read, zero wait states
        m0(T_NONSEQ, 32'h2000_0000, 1'b0, 32'h0);
        mid();
        chk("t1_htrans", HTRANS, 2'b10);
        chk("t1_haddr", HADDR, 32'h2000_0000);
        chk("t1_hmaster", HMASTER, 1'b0);
        chk("t1_m0_hready_a", M0_HREADY, 1'b1);
        nxt();
        m0(T_IDLE, 32'h0, 1'b0, 32'h0);
        slv(1'b1, 1'b0, 32'hDEAD_BEEF);
        mid();
        chk("t1_m0_hrdata", M0_HRDATA, 32'hDEAD_BEEF);
        chk("t1_m0_hready_d", M0_HREADY, 1'b1);
        chk("t1_htrans_idle", HTRANS, 2'b00);
        nxt();

        // ---- simultaneous writes: M1 first, M0 captured and stalled one cycle
        slv(1'b1, 1'b0, 32'h0);
        m0(T_NONSEQ, 32'h100, 1'b1, 32'h0);
        m1(T_SEQ, 32'h200, 1'b1, 32'h0);  // SEQ must go out as NONSEQ
        mid();
        chk("t2_haddr_m1", HADDR, 32'h200);
        chk("t2_htrans_a", HTRANS, 2'b10);
        chk("t2_hmaster_a", HMASTER, 1'b1);
        chk("t2_hwrite", HWRITE, 1'b1);
        nxt();
        m0(T_IDLE, 32'h0, 1'b0, 32'h11);
        m1(T_IDLE, 32'h0, 1'b0, 32'h22);
        mid();
        chk("t2_hwdata_m1", HWDATA, 32'h22);
        chk("t2_haddr_m0", HADDR, 32'h100);
        chk("t2_hmaster_b", HMASTER, 1'b0);
        chk("t2_m0_hready_stall", M0_HREADY, 1'b0);
        chk("t2_m1_hready", M1_HREADY, 1'b1);
        nxt();
        mid();
        chk("t2_hwdata_m0", HWDATA, 32'h11);
        chk("t2_m0_hready_done", M0_HREADY, 1'b1);
        chk("t2_htrans_idle", HTRANS, 2'b00);
        nxt();

        // ---- M1 read captured during 3 slave wait states on an M0 write
        m0(T_NONSEQ, 32'h300, 1'b1, 32'h0);
        m1(T_IDLE, 32'h0, 1'b0, 32'h0);
        mid();
        chk("t3_hmaster_a", HMASTER, 1'b0);
        nxt();
        m0(T_IDLE, 32'h0, 1'b0, 32'h33);
        m1(T_NONSEQ, 32'h400, 1'b0, 32'h0);
        slv(1'b0, 1'b0, 32'h0);
        mid();
        chk("t3_hwdata", HWDATA, 32'h33);
        chk("t3_haddr_live", HADDR, 32'h400);
        chk("t3_m0_hready_w1", M0_HREADY, 1'b0);
        chk("t3_m1_hready_w1", M1_HREADY, 1'b1);
        nxt();
        m1(T_IDLE, 32'h0, 1'b0, 32'h0);
        mid();
        chk("t3_m1_hready_w2", M1_HREADY, 1'b0);
        chk("t3_haddr_pend", HADDR, 32'h400);
        chk("t3_htrans_pend", HTRANS, 2'b10);
        nxt();
        mid();
        chk("t3_m1_hready_w3", M1_HREADY, 1'b0);
        nxt();
        slv(1'b1, 1'b0, 32'h0);
        mid();
        chk("t3_m0_hready_done", M0_HREADY, 1'b1);
        chk("t3_m1_hready_replay", M1_HREADY, 1'b0);
        chk("t3_hmaster_replay", HMASTER, 1'b1);
        chk("t3_hwrite_replay", HWRITE, 1'b0);
        nxt();
        slv(1'b1, 1'b0, 32'h44);
        mid();
        chk("t3_m1_hready_done", M1_HREADY, 1'b1);
        chk("t3_m1_hrdata", M1_HRDATA, 32'h44);
        chk("t3_htrans_idle", HTRANS, 2'b00);
        nxt();

        // ---- ERROR on M1, pending M0 read still completes
        slv(1'b1, 1'b0, 32'h0);
        m0(T_NONSEQ, 32'h600, 1'b0, 32'h0);
        m1(T_NONSEQ, 32'h500, 1'b1, 32'h0);
        nxt();
        m0(T_IDLE, 32'h0, 1'b0, 32'h0);
        m1(T_IDLE, 32'h0, 1'b0, 32'h55);
        slv(1'b0, 1'b1, 32'h0);
        mid();
        chk("t4_m1_hresp_1", M1_HRESP, 1'b1);
        chk("t4_m0_hresp_1", M0_HRESP, 1'b0);
        chk("t4_m1_hready_1", M1_HREADY, 1'b0);
        chk("t4_m0_hready_1", M0_HREADY, 1'b0);
        chk("t4_haddr_m0", HADDR, 32'h600);
        nxt();
        slv(1'b1, 1'b1, 32'h0);
        mid();
        chk("t4_m1_hresp_2", M1_HRESP, 1'b1);
        chk("t4_m1_hready_2", M1_HREADY, 1'b1);
        chk("t4_m0_hresp_2", M0_HRESP, 1'b0);
        chk("t4_m0_hready_2", M0_HREADY, 1'b0);
        nxt();
        slv(1'b1, 1'b0, 32'h66);
        mid();
        chk("t4_m0_hready_done", M0_HREADY, 1'b1);
        chk("t4_m0_hrdata", M0_HRDATA, 32'h66);
        chk("t4_m1_hresp_clear", M1_HRESP, 1'b0);
        nxt();

        // ---- async reset with M0 pending and M1 in its data phase
        slv(1'b1, 1'b0, 32'h0);
        m0(T_NONSEQ, 32'h800, 1'b0, 32'h0);
        m1(T_NONSEQ, 32'h700, 1'b0, 32'h0);
        mid();
        chk("t5_hmaster_a", HMASTER, 1'b1);
        nxt();
        m0(T_IDLE, 32'h0, 1'b0, 32'h0);
        m1(T_IDLE, 32'h0, 1'b0, 32'h0);
        slv(1'b0, 1'b0, 32'h0);
        mid();
        chk("t5_m0_hready_pre", M0_HREADY, 1'b0);
        chk("t5_htrans_pre", HTRANS, 2'b10);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("t5_htrans_rst", HTRANS, 2'b00);
        chk("t5_m0_hready_rst", M0_HREADY, 1'b1);
        chk("t5_m1_hready_rst", M1_HREADY, 1'b1);
        chk("t5_hmaster_rst", HMASTER, 1'b0);
        slv(1'b1, 1'b0, 32'h0);
        mid();
        HRESETn = 1'b1;
        nxt();

        // ---- M1 back-to-back while M0 waits (starve guard limit 4 if built)
        m0(T_NONSEQ, 32'h900, 1'b0, 32'h0);
        m1(T_NONSEQ, 32'h1000, 1'b0, 32'h0);
        mid();
        chk("t6_hmaster_0", HMASTER, 1'b1);
        nxt();
        m0(T_IDLE, 32'h0, 1'b0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            m1(T_NONSEQ, 32'h1000 + 32'(i), 1'b0, 32'h0);
            mid();
            chk($sformatf("t6_hmaster_%0d", i), HMASTER, (Guard && i == 4) ? 1'b0 : 1'b1);
            nxt();
        end
        m1(T_IDLE, 32'h0, 1'b0, 32'h0);
        mid();
        chk("t6_hmaster_5", HMASTER, Guard ? 1'b1 : 1'b0);
        chk("t6_m1_hready_5", M1_HREADY, Guard ? 1'b0 : 1'b1);
        nxt();
        mid();
        chk("t6_htrans_drained", HTRANS, 2'b00);
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
